// File: rtl/piezo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : piezo_pkg
// Description : Shared state encoding and divider helper for the piezo timer.
// Revision    : 1.0 - initial release
// ============================================================================
package piezo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic int calc_div(input int clk_freq, input int tick_hz);
        return clk_freq / tick_hz;
    endfunction

endpackage
`default_nettype wire

// File: rtl/piezo_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : piezo_tick_gen
// Description : Free-running 0..DIV-1 prescaler with clear and hold.
// Revision    : 1.0 - initial release
// ============================================================================
module piezo_tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic hold,
    output logic tick
);

    localparam int                c_CNT_W = $clog2(DIV);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (!hold) begin
            if (r_cnt == c_LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign tick = (r_cnt == c_LAST) && !hold;

endmodule
`default_nettype wire

// File: rtl/piezo_dur_timer.sv
`default_nettype none
// ============================================================================
// Module      : piezo_dur_timer
// Description : Plays one note for note_dur ticks, reps times, with gaps.
// Revision    : 1.0 - initial release
// ============================================================================
module piezo_dur_timer
    import piezo_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int TICK_HZ   = 100,
    parameter int DUR_W     = 8,
    parameter int REP_W     = 3,
    parameter int GAP_TICKS = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic [DUR_W-1:0] note_dur,
    input  logic [REP_W-1:0] reps,
    output logic             tone_en,
    output logic             busy,
    output logic             done,
    output logic [REP_W-1:0] rep_left
);

    localparam int                 c_DIV      = calc_div(CLK_FREQ, TICK_HZ);
    localparam int                 c_GAP_W    = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    state_t             r_state;
    logic [DUR_W-1:0]   r_note_dur;
    logic [DUR_W-1:0]   r_dur_cnt;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic [REP_W-1:0]   r_rep_left;
    logic               r_tone;
    logic               r_busy;
    logic               r_done;

    logic w_tick;
    logic w_accept;
    logic w_dur_last;

    assign w_accept   = (r_state == IDLE) && start && !abort;
    assign w_dur_last = (r_dur_cnt == (r_note_dur - DUR_W'(1)));

    piezo_tick_gen #(
        .DIV (c_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_accept),
        .hold (pause),
        .tick (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_note_dur <= '0;
            r_dur_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_rep_left <= '0;
            r_tone     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                // Abort outranks a coincident final tick, so no done is raised.
                r_state    <= IDLE;
                r_dur_cnt  <= '0;
                r_gap_cnt  <= '0;
                r_rep_left <= '0;
                r_tone     <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_note_dur <= note_dur;
                            r_dur_cnt  <= '0;
                            r_gap_cnt  <= '0;
                            if ((note_dur == '0) || (reps == '0)) begin
                                r_done <= 1'b1;
                            end else begin
                                r_state    <= TONE;
                                r_rep_left <= reps;
                                r_tone     <= 1'b1;
                                r_busy     <= 1'b1;
                            end
                        end
                    end
                    TONE: begin
                        if (w_tick) begin
                            if (w_dur_last) begin
                                r_dur_cnt <= '0;
                                if (r_rep_left == REP_W'(1)) begin
                                    r_state    <= IDLE;
                                    r_rep_left <= '0;
                                    r_tone     <= 1'b0;
                                    r_busy     <= 1'b0;
                                    r_done     <= 1'b1;
                                end else begin
                                    r_rep_left <= r_rep_left - REP_W'(1);
                                    if (GAP_TICKS != 0) begin
                                        r_state <= GAP;
                                        r_tone  <= 1'b0;
                                    end
                                end
                            end else begin
                                r_dur_cnt <= r_dur_cnt + DUR_W'(1);
                            end
                        end
                    end
                    GAP: begin
                        if (w_tick) begin
                            if (r_gap_cnt == c_GAP_LAST) begin
                                r_gap_cnt <= '0;
                                r_state   <= TONE;
                                r_tone    <= 1'b1;
                            end else begin
                                r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_tone  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Pause gates the tone within the same cycle so the piezo falls silent at once.
    assign tone_en  = r_tone && !pause;
    assign busy     = r_busy;
    assign done     = r_done;
    assign rep_left = r_rep_left;

endmodule
`default_nettype wire

// File: tb/tb_piezo_dur_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_piezo_dur_timer
// Description : Scoreboard bench for piezo_dur_timer (DIV=10, GAP_TICKS=5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piezo_dur_timer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       pause;
    logic       abort;
    logic [7:0] note_dur;
    logic [2:0] reps;
    logic       tone_en;
    logic       busy;
    logic       done;
    logic [2:0] rep_left;

    typedef struct packed {
        logic       tone;
        logic       busy;
        logic       done;
        logic [2:0] rep;
    } exp_t;

    exp_t  exp_q[$];
    int    cyc_q[$];
    string cur_name;
    int    n_checks;
    int    n_fail;

    piezo_dur_timer #(
        .CLK_FREQ  (1000),
        .TICK_HZ   (100),
        .DUR_W     (8),
        .REP_W     (3),
        .GAP_TICKS (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pause    (pause),
        .abort    (abort),
        .note_dur (note_dur),
        .reps     (reps),
        .tone_en  (tone_en),
        .busy     (busy),
        .done     (done),
        .rep_left (rep_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic in_rng(input int c, input int a, input int b);
        return (c >= a) && (c <= b);
    endfunction

    // Expected per-cycle outputs: tone windows A and B, busy window, done cycle;
    // rep_left is 2 up to r2_end inside the busy window, 1 afterwards, 0 outside.
    task automatic push_seq(input int n, input int ta0, input int ta1,
                            input int tb0, input int tb1, input int bz0,
                            input int bz1, input int dn, input int r2_end);
        exp_t e;
        for (int c = 0; c < n; c++) begin
            e.tone = in_rng(c, ta0, ta1) || in_rng(c, tb0, tb1);
            e.busy = in_rng(c, bz0, bz1);
            e.done = (c == dn);
            e.rep  = e.busy ? ((c <= r2_end) ? 3'd2 : 3'd1) : 3'd0;
            exp_q.push_back(e);
            cyc_q.push_back(c);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            exp_t a;
            int   c;
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            a = {tone_en, busy, done, rep_left};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s cycle=%0d got{tone,busy,done,rep}=%b_%b_%b_%0d exp=%b_%b_%b_%0d",
                         cur_name, c, a.tone, a.busy, a.done, a.rep,
                         e.tone, e.busy, e.done, e.rep);
            end
        end
    end

    task automatic check_zero(input string nm);
        n_checks++;
        if ({tone_en, busy, done, rep_left} !== 6'b0) begin
            n_fail++;
            $display("FAIL %s got{tone,busy,done,rep}=%b_%b_%b_%0d exp=0_0_0_0",
                     nm, tone_en, busy, done, rep_left);
        end
    endtask

    // Drives one scenario; cycle 0 is the cycle start is high. Called at posedge+1.
    task automatic run(input int n, input logic [7:0] nd, input logic [2:0] rp,
                       input int start2_c, input int abort_c, input int p0,
                       input int p1, input int rst_c);
        for (int c = 0; c < n; c++) begin
            start = (c == 0) || (c == start2_c);
            abort = (c == abort_c);
            pause = in_rng(c, p0, p1);
            if (c == 0) begin
                note_dur = nd;
                reps     = rp;
            end else if (c == start2_c) begin
                note_dur = 8'd9;
                reps     = 3'd3;
            end else if (c == 1) begin
                note_dur = 8'd200;
                reps     = 3'd7;
            end
            if (c == rst_c) begin
                rst = 1'b1;
                #1;
                check_zero({cur_name, "_async_rst"});
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
        pause = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_%s left=%0d required=0", cur_name, exp_q.size());
            exp_q.delete();
            cyc_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cur_name = "reset";
        rst      = 1'b1;
        start    = 1'b0;
        pause    = 1'b0;
        abort    = 1'b0;
        note_dur = 8'd0;
        reps     = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_held");
        rst = 1'b0;
        push_seq(3, 1, 0, 1, 0, 1, 0, -1, -1);
        drain();

        cur_name = "single";
        @(posedge clk); #1;
        push_seq(33, 1, 30, 1, 0, 1, 30, 31, -1);
        run(33, 8'd3, 3'd1, -1, -1, 1, 0, -1);

        cur_name = "repeats";
        push_seq(113, 1, 30, 81, 110, 1, 110, 111, 30);
        run(113, 8'd3, 3'd2, -1, -1, 1, 0, -1);

        cur_name = "degen_dur0";
        push_seq(4, 1, 0, 1, 0, 1, 0, 1, -1);
        run(4, 8'd0, 3'd4, -1, -1, 1, 0, -1);

        cur_name = "degen_rep0";
        push_seq(4, 1, 0, 1, 0, 1, 0, 1, -1);
        run(4, 8'd5, 3'd0, -1, -1, 1, 0, -1);

        cur_name = "pause";
        push_seq(40, 1, 11, 19, 37, 1, 37, 38, -1);
        run(40, 8'd3, 3'd1, -1, -1, 12, 18, -1);

        cur_name = "abort_mid";
        push_seq(35, 1, 15, 1, 0, 1, 15, -1, 15);
        run(35, 8'd3, 3'd2, -1, 15, 1, 0, -1);

        cur_name = "abort_final_tick";
        push_seq(35, 1, 30, 1, 0, 1, 30, -1, -1);
        run(35, 8'd3, 3'd1, -1, 30, 1, 0, -1);

        cur_name = "abort_with_start";
        push_seq(5, 1, 0, 1, 0, 1, 0, -1, -1);
        run(5, 8'd3, 3'd1, -1, 0, 1, 0, -1);

        cur_name = "busy_reject";
        push_seq(33, 1, 30, 1, 0, 1, 30, 31, -1);
        run(33, 8'd3, 3'd1, 5, -1, 1, 0, -1);

        cur_name = "reset_mid";
        push_seq(20, 1, 19, 1, 0, 1, 19, -1, -1);
        run(21, 8'd3, 3'd1, -1, -1, 1, 0, 20);

        cur_name = "after_reset";
        push_seq(33, 1, 30, 1, 0, 1, 30, 31, -1);
        run(33, 8'd3, 3'd1, -1, -1, 1, 0, -1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piezo_dur_timer.md
Name: piezo_dur_timer

Overview:
Parametrised successor to the piezo note-duration counter. It contains its own 1/TICK_HZ prescaler and plays one note for note_dur ticks, repeated reps times, with a fixed silent gap between repeats. It adds a start/busy/done handshake, pause and abort. It sits between the tune sequencer, which issues start, and the piezo frequency generator, which is gated by tone_en.

Parameters:
CLK_FREQ, 50_000_000, input clock frequency in Hz
TICK_HZ, 100, duration tick rate in Hz; DIV = CLK_FREQ/TICK_HZ clocks per tick; DIV must be at least 2
DUR_W, 8, width of note_dur in ticks
REP_W, 3, width of reps
GAP_TICKS, 5, silent ticks between repeats; 0 means back-to-back repeats

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle request; sampled only in IDLE
pause  in  1  level; freezes prescaler and all counters; forces tone_en low
abort  in  1  one-cycle; cancels the note sequence
note_dur  in  DUR_W  note length in ticks; latched on accepted start
reps  in  REP_W  number of times to play the note; latched on accepted start
tone_en  out  1  enables the piezo frequency generator
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on normal completion
rep_left  out  REP_W  repeats remaining, including the current one

Behaviour:
- Reset: the following are forced asynchronously:
  - state=IDLE
  - prescaler=0, dur_cnt=0, gap_cnt=0
  - rep_left=0
  - tone_en=0, busy=0, done=0
- The one clock is clk; reset is asynchronous and active-high on rst.
- States and transitions:
  - IDLE: on start and !abort:
    - latch note_dur and reps; clear prescaler and dur_cnt.
    - If note_dur==0 or reps==0: stay in IDLE and pulse done the next cycle.
    - Otherwise go to TONE with rep_left=reps.
  - TONE: dur_cnt increments on each tick. On a tick with dur_cnt==note_dur_q-1:
    - if rep_left==1: go to IDLE and pulse done.
    - otherwise: decrement rep_left and clear dur_cnt. Go to GAP, or straight to TONE if GAP_TICKS==0.
  - GAP: gap_cnt increments on each tick. On a tick with gap_cnt==GAP_TICKS-1, clear gap_cnt and go to TONE.
- Tick:
  - The prescaler counts 0..DIV-1 and wraps to 0.
  - tick is high when prescaler==DIV-1 and !pause.
  - The prescaler is cleared on an accepted start.
  - The prescaler runs continuously through TONE and GAP.
- Outputs:
  - tone_en is registered-state decode: (state==TONE) && !pause.
  - done is a registered one-cycle pulse, asserted in the first IDLE cycle after completion.
- Latency:
  - start high in cycle 0 gives tone_en high from cycle 1.
  - The tone lasts exactly note_dur*DIV cycles.
- Pause: everything is frozen, including an in-progress GAP. Releasing pause resumes with no lost or extra cycles.
- Abort: highest priority. The next cycle has state=IDLE, tone_en=0, busy=0, rep_left=0, and no done pulse. Abort beats a coincident final tick, and beats a coincident start in IDLE.
- start while busy is ignored; latched values are not disturbed.
- note_dur and reps may change after acceptance with no effect on the running sequence.
- Width rules:
  - dur_cnt is DUR_W bits and gap_cnt is clog2(GAP_TICKS+1) bits, minimum 1.
  - No overflow is possible, because each counter's compare terminates it before wrap.
  - The prescaler is clog2(DIV) bits.
- Reset asserted mid-note returns everything to reset values immediately (asynchronously).

Decomposition:
- Package piezo_pkg holds:
  - the state enum typedef (IDLE, TONE, GAP)
  - a function computing DIV from CLK_FREQ and TICK_HZ
- One sub-module is natural: piezo_tick_gen. It is the prescaler, with inputs clr and hold and a tick output; it is parametrised by DIV.

Test Plan (CLK_FREQ=1000, TICK_HZ=100, so DIV=10; GAP_TICKS=5):
- Single note: note_dur=3, reps=1, start in cycle 0 -> tone_en high cycles 1..30, done in cycle 31 only, busy high cycles 1..30.
- Repeats: note_dur=3, reps=2 -> tone_en cycles 1..30, silent cycles 31..80, tone_en cycles 81..110, done in cycle 111; rep_left 2 then 1.
- Degenerate: note_dur=0, reps=4 (and separately note_dur=5, reps=0) -> done in cycle 1, tone_en never high, busy never high.
- Pause: single note as above with pause held in cycles 12..18 -> tone_en low during the pause, done in cycle 38.
- Abort: abort in cycle 15 during TONE -> cycle 16 has tone_en=0, busy=0, rep_left=0; done never pulses. Abort coincident with the final tick -> no done.
- Busy rejection: a second start in cycle 5 with note_dur=9 -> ignored; timing identical to the single-note case. Also assert rst in cycle 20 -> all outputs 0 immediately.
